// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared LFSR polynomial, step function and checker state type
package rng_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Fibonacci step: shift left, feedback is the XOR of the tapped bits 15,13,12,10
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] d);
    return {d[LFSR_W-2:0], ^(d & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// rtl/lfsr_seq_checker_if.sv - sample stream and force-sync seed into the checker
interface lfsr_seq_checker_if;
  import rng_pkg::*;

  logic              in_valid;
  logic [LFSR_W-1:0] in_data;
  logic              seed_load;
  logic [LFSR_W-1:0] seed;

  modport master (output in_valid, in_data, seed_load, seed);
  modport slave  (input  in_valid, in_data, seed_load, seed);

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter that sticks at all-ones, cleared only by rst
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_seq_checker.sv
// rtl/lfsr_seq_checker.sv - self-synchronising LFSR sequence checker with error/match counts
module lfsr_seq_checker
  import rng_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  lfsr_seq_checker_if.slave smp,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = $clog2(UNLOCK_CNT + 1);
  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_CNT);
  localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(UNLOCK_CNT);

  state_t            state, state_nxt;
  logic [LFSR_W-1:0] exp_q, exp_nxt;
  logic [RUN_W-1:0]  run_q, run_nxt;
  logic [MISS_W-1:0] miss_q, miss_nxt;
  logic              locked_nxt, err_nxt, match_inc;
  logic              sample_zero, sample_hit;

  assign sample_zero = (smp.in_data == '0);
  assign sample_hit  = (smp.in_data == exp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      exp_q     <= '0;
      run_q     <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      exp_q     <= exp_nxt;
      run_q     <= run_nxt;
      miss_q    <= miss_nxt;
      locked    <= locked_nxt;
      err_pulse <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_q;
    run_nxt   = run_q;
    miss_nxt  = miss_q;
    // A seed load wins over any sample presented in the same cycle
    if (smp.seed_load) begin
      state_nxt = VERIFY;
      exp_nxt   = smp.seed;
      run_nxt   = '0;
    end else if (smp.in_valid) begin
      unique case (state)
        HUNT: begin
          if (!sample_zero) begin
            state_nxt = VERIFY;
            exp_nxt   = lfsr_next(smp.in_data);
            run_nxt   = '0;
          end
        end
        VERIFY: begin
          if (sample_zero) begin
            state_nxt = HUNT;
          end else if (sample_hit) begin
            exp_nxt = lfsr_next(exp_q);
            run_nxt = run_q + 1'b1;
            if (run_nxt == RUN_LOCK) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            exp_nxt = lfsr_next(smp.in_data);
            run_nxt = '0;
          end
        end
        LOCKED: begin
          // Flywheel: keep phase on every sample so a lone bad word costs one error
          exp_nxt = lfsr_next(exp_q);
          if (sample_hit) begin
            miss_nxt = '0;
          end else begin
            miss_nxt = miss_q + 1'b1;
            if (miss_nxt == MISS_DROP) begin
              state_nxt = HUNT;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    locked_nxt = (state_nxt == LOCKED);
    err_nxt    = 1'b0;
    match_inc  = 1'b0;
    if (!smp.seed_load && smp.in_valid && (state == LOCKED)) begin
      err_nxt   = !sample_hit;
      match_inc = sample_hit;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_nxt),
    .count (err_count)
  );

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match_inc),
    .count (match_count)
  );

endmodule
